// File: rtl/spi_slave_pkg.sv
// spi_slave_pkg: command field positions, FSM encoding and regfile depth for the SPI register slave.
package spi_slave_pkg;
    localparam int RW_BIT    = 7;
    localparam int MS_BIT    = 6;
    localparam int ADDR_MSB  = 5;
    localparam int REG_DEPTH = 64;
    typedef logic [ADDR_MSB:0] addr_t;
    typedef enum logic [1:0] {IDLE, CMD, DATA} state_e;
    // Burst advance wraps naturally at the 6-bit boundary.
    function automatic addr_t next_addr(input addr_t a, input logic ms);
        return ms ? a + addr_t'(1) : a;
    endfunction
endpackage

// File: rtl/spi_slave_regs_if.sv
// spi_slave_regs_if: SPI pins plus the local register port and SPI-write observation signals.
interface spi_slave_regs_if;
    import spi_slave_pkg::*;
    logic       spi_sck;
    logic       spi_mosi;
    logic       spi_csn;
    logic       spi_miso;
    logic       loc_we;
    addr_t      loc_addr;
    logic [7:0] loc_wdata;
    logic [7:0] loc_rdata;
    logic       wr_valid;
    addr_t      wr_addr;
    logic [7:0] wr_data;
    logic       busy;
    modport master (
        output spi_sck, spi_mosi, spi_csn, loc_we, loc_addr, loc_wdata,
        input  spi_miso, loc_rdata, wr_valid, wr_addr, wr_data, busy
    );
    modport slave (
        input  spi_sck, spi_mosi, spi_csn, loc_we, loc_addr, loc_wdata,
        output spi_miso, loc_rdata, wr_valid, wr_addr, wr_data, busy
    );
endinterface

// File: rtl/spi_edge_sync.sv
// spi_edge_sync: multi-flop synchronizer with rise/fall pulses from the last two synchronized samples.
module spi_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);
    logic [SYNC_STAGES:0] sync_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) sync_q <= '0;
        else sync_q <= {sync_q[SYNC_STAGES-1:0], d_i};
    end
    assign q_o    = sync_q[SYNC_STAGES-1];
    assign rise_o = sync_q[SYNC_STAGES-1] & ~sync_q[SYNC_STAGES];
    assign fall_o = ~sync_q[SYNC_STAGES-1] & sync_q[SYNC_STAGES];
endmodule

// File: rtl/spi_slave_regs.sv
// spi_slave_regs: mode-3 SPI responder over a 64x8 regfile, accelerometer-style command byte.
module spi_slave_regs
    import spi_slave_pkg::*;
#(
    parameter addr_t      WHOAMI_ADDR = 6'h0F,
    parameter logic [7:0] WHOAMI_VAL  = 8'h33,
    parameter int         SYNC_STAGES = 2
) (
    input logic             clk_in,
    input logic             nrst,
    spi_slave_regs_if.slave bus
);
    state_e     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [6:0] rx_q, rx_d;
    logic [7:0] tx_q, tx_d;
    logic       rw_q, rw_d, ms_q, ms_d;
    addr_t      addr_q, addr_d, wr_addr_q, wr_addr_d;
    logic       miso_q, miso_d, wr_valid_q, wr_valid_d;
    logic [7:0] wr_data_q, wr_data_d, loc_rdata_q, loc_rdata_d;
    logic [7:0] regs_q [REG_DEPTH];
    logic       sck_rise, sck_fall, mosi_s, cs_rise, cs_fall, spi_we;
    logic       sck_q_unused, mosi_rise_unused, mosi_fall_unused, csn_q_unused;
    logic [7:0] byte_in;
    logic       last;
    spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sck (
        .clk_i(clk_in), .rst_ni(nrst), .d_i(bus.spi_sck),
        .q_o(sck_q_unused), .rise_o(sck_rise), .fall_o(sck_fall)
    );
    spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_mosi (
        .clk_i(clk_in), .rst_ni(nrst), .d_i(bus.spi_mosi),
        .q_o(mosi_s), .rise_o(mosi_rise_unused), .fall_o(mosi_fall_unused)
    );
    spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_csn (
        .clk_i(clk_in), .rst_ni(nrst), .d_i(bus.spi_csn),
        .q_o(csn_q_unused), .rise_o(cs_rise), .fall_o(cs_fall)
    );
    function automatic logic [7:0] rd(input addr_t a);
        return (a == WHOAMI_ADDR) ? WHOAMI_VAL : regs_q[a];
    endfunction
    assign byte_in = {rx_q, mosi_s};
    assign last    = sck_rise && cnt_q == 3'd7;
    always_ff @(posedge clk_in or negedge nrst) begin
        if (!nrst) state_q <= IDLE;
        else state_q <= state_d;
    end
    always_comb begin
        state_d = cs_rise ? IDLE :
                  cs_fall ? CMD :
                  (state_q == CMD && last) ? DATA : state_q;
    end
    always_comb begin
        cnt_d      = cnt_q;
        rx_d       = rx_q;
        tx_d       = tx_q;
        rw_d       = rw_q;
        ms_d       = ms_q;
        addr_d     = addr_q;
        miso_d     = miso_q;
        wr_valid_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        spi_we     = 1'b0;
        if (cs_rise || cs_fall) begin
            cnt_d  = '0;
            miso_d = 1'b0;
        end else if (state_q != IDLE) begin
            if (sck_rise) begin
                cnt_d = cnt_q + 3'd1;
                rx_d  = byte_in[6:0];
            end
            if (state_q == CMD && last) begin
                rw_d   = byte_in[RW_BIT];
                ms_d   = byte_in[MS_BIT];
                addr_d = byte_in[ADDR_MSB:0];
                tx_d   = byte_in[RW_BIT] ? rd(byte_in[ADDR_MSB:0]) : tx_q;
            end
            if (state_q == DATA && rw_q) begin
                if (sck_fall) begin
                    miso_d = tx_q[7];
                    tx_d   = {tx_q[6:0], 1'b0};
                end
                if (last) begin
                    addr_d = next_addr(addr_q, ms_q);
                    tx_d   = rd(addr_d);
                end
            end
            if (state_q == DATA && !rw_q && last) begin
                spi_we     = addr_q != WHOAMI_ADDR;
                wr_valid_d = 1'b1;
                wr_addr_d  = addr_q;
                wr_data_d  = byte_in;
                addr_d     = next_addr(addr_q, ms_q);
            end
        end
        // Write-first: show whatever the regfile will hold after this edge.
        loc_rdata_d = (bus.loc_addr == WHOAMI_ADDR) ? WHOAMI_VAL :
                      (spi_we && addr_q == bus.loc_addr) ? byte_in :
                      bus.loc_we ? bus.loc_wdata : regs_q[bus.loc_addr];
    end
    always_ff @(posedge clk_in or negedge nrst) begin
        if (!nrst) begin
            cnt_q       <= '0;
            rx_q        <= '0;
            tx_q        <= '0;
            rw_q        <= 1'b0;
            ms_q        <= 1'b0;
            addr_q      <= '0;
            miso_q      <= 1'b0;
            wr_valid_q  <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            loc_rdata_q <= '0;
        end else begin
            cnt_q       <= cnt_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            rw_q        <= rw_d;
            ms_q        <= ms_d;
            addr_q      <= addr_d;
            miso_q      <= miso_d;
            wr_valid_q  <= wr_valid_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            loc_rdata_q <= loc_rdata_d;
        end
    end
    // SPI commit takes priority over a same-cycle local write to the same entry.
    always_ff @(posedge clk_in or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < REG_DEPTH; i++) regs_q[i] <= '0;
        end else begin
            for (int i = 0; i < REG_DEPTH; i++)
                if (spi_we && addr_q == addr_t'(i)) regs_q[i] <= byte_in;
                else if (bus.loc_we && bus.loc_addr == addr_t'(i)) regs_q[i] <= bus.loc_wdata;
        end
    end
    assign bus.spi_miso  = miso_q;
    assign bus.wr_valid  = wr_valid_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.loc_rdata = loc_rdata_q;
    assign bus.busy      = state_q != IDLE;
endmodule

// File: doc/spi_slave_regs.md
Name: spi_slave_regs

Overview:
- SPI responder (mode 3, CPOL=1/CPHA=1) exposing a 64 x 8-bit register file, with the same command format as the on-board accelerometer.
  - Command byte: bit7 = RW (1 = read), bit6 = MS (auto-increment), bits5:0 = address.
  - Command byte is followed by one or more data bytes.
- Used as the far end of spi_master: as a sensor model on an FPGA-to-FPGA link, and as a synthesizable bench target.
- SCK/MOSI/CSn are oversampled in the clk_in domain.
- Local fabric logic updates registers (e.g. sample data) and observes SPI writes.

Parameters:
- WHOAMI_ADDR, 6'h0F: address of the read-only ID register.
- WHOAMI_VAL, 8'h33: value returned at WHOAMI_ADDR. Writes to it are ignored.
- SYNC_STAGES, 2: synchronizer flops on spi_sck, spi_mosi and spi_csn (minimum 2).

Ports:
- clk_in  input  1  system clock; must be at least 8x the SCK frequency.
- nrst  input  1  asynchronous active-low reset.
- spi_sck  input  1  SPI clock from the master; idles high.
- spi_mosi  input  1  master-to-slave data.
- spi_csn  input  1  chip select, active low.
- spi_miso  output  1  slave-to-master data.
- loc_we  input  1  local register write enable.
- loc_addr  input  6  local register address.
- loc_wdata  input  8  local write data.
- loc_rdata  output  8  registered read of regfile[loc_addr], 1-cycle latency.
- wr_valid  output  1  one-cycle pulse when an SPI data byte is committed.
- wr_addr  output  6  address of the committed byte.
- wr_data  output  8  committed byte value.
- busy  output  1  high while CSn is asserted (synchronized).

Behaviour:
- **Reset.**
  - FSM = IDLE; bit counter = 0; shift registers = 0; every regfile entry = 0x00.
  - Outputs: spi_miso = 0, wr_valid = 0, wr_addr = 0, wr_data = 0, loc_rdata = 0, busy = 0.
  - Asserting nrst mid-transfer aborts the transfer; the master's remaining clocks are ignored until a fresh CSn falling edge.
- **Synchronization.**
  - Inputs pass through SYNC_STAGES flops.
  - rise/fall/cs_fall/cs_rise are one-cycle pulses derived from the last two synchronized samples.
  - Edges are acted on SYNC_STAGES+1 clk_in cycles after the pin event.
  - SCK half-period must be at least 4 clk_in cycles.
- **IDLE.**
  - spi_miso = 0; busy = 0.
  - cs_fall → CMD, bit counter = 0, busy = 1.
- **CMD.**
  - On each rise, shift in MOSI MSB-first.
  - After the 8th rise:
    - latch rw, ms and addr;
    - if rw = 1, load tx_shift = regfile[addr] (WHOAMI_VAL when addr = WHOAMI_ADDR) in the same cycle;
    - → DATA with bit counter = 0.
  - spi_miso is held at 0 throughout CMD.
- **DATA.**
  - Read (rw = 1):
    - on each fall, spi_miso = tx_shift[7] and tx_shift shifts left; bit7 of the data byte appears on the first fall after the 8th command rise;
    - after the 8th rise of a byte, advance addr, then reload tx_shift from the new addr.
  - Write (rw = 0):
    - on each rise, shift MOSI into rx_shift;
    - after the 8th rise, write regfile[addr] = byte (skipped for WHOAMI_ADDR);
    - pulse wr_valid for 1 cycle with wr_addr/wr_data; advance addr.
    - The wr_valid pulse is issued even for WHOAMI_ADDR.
  - Address advance: if ms = 1, addr + 1 modulo 64 (0x3F wraps to 0x00); if ms = 0, addr is unchanged.
- **cs_rise (any state).**
  - → IDLE; a partial byte (counter ≠ 0) is discarded with no write and no wr_valid; spi_miso = 0.
- **cs_fall while not IDLE:** cannot occur without an intervening cs_rise. If seen, restart in CMD.
- **Local port.**
  - loc_we writes regfile[loc_addr] in the cycle it is asserted.
  - If an SPI commit and loc_we target the same address in the same cycle, the SPI write wins.
  - A local write landing after tx_shift was loaded does not alter the byte in flight (snapshot at load).
  - loc_rdata reflects a same-cycle write on the next cycle, i.e. write-first semantics.

Decomposition:
- Package spi_slave_pkg holds:
  - command bit positions: RW_BIT = 7, MS_BIT = 6, ADDR_MSB = 5;
  - FSM state encoding: IDLE, CMD, DATA;
  - constant REG_DEPTH = 64.
- Sub-module spi_edge_sync: synchronizer plus edge detector. It is parameterized by SYNC_STAGES and instantiated once per input.
- The regfile is inferred inside spi_slave_regs.

Test Plan:
- **WHO_AM_I read.** spi_master sends 0x8F00 with nbits = 16 → miso_data[7:0] = 0x33. No wr_valid pulse.
- **Single write then read.**
  - Write cmd 0x20 + data 0x57 → one wr_valid pulse with wr_addr = 0x20, wr_data = 0x57.
  - Then read cmd 0xA0 + 0x00 → returns 0x57.
- **Burst write, auto-increment with wrap.**
  - Cmd 0x7E (ms = 1, addr 0x3E) with data 0x11, 0x22, 0x33 → regs 0x3E = 0x11, 0x3F = 0x22, 0x00 = 0x33.
  - Three wr_valid pulses.
- **Local update, no-increment read.**
  - loc_we writes 0x28 = 0xA5 and 0x29 = 0x5A.
  - Read 0xA8 with 3 data bytes → 0xA5, 0xA5, 0xA5.
  - Read 0xE8 with 2 data bytes → 0xA5, 0x5A.
- **Abort mid-byte.**
  - Write cmd 0x10, then CSn deasserted after 5 data bits → no wr_valid; reg 0x10 keeps its prior value.
  - The next transaction behaves normally.
- **Reset mid-read and collision.**
  - nrst asserted mid-transfer → spi_miso = 0, busy = 0, regfile zeroed.
  - SPI commit and loc_we to the same address in the same cycle → SPI data stored.
